// File: rtl/alu_pkg.sv
// Shared ALU result-stage types: opcodes, field widths, error bit indices and the FIFO entry layout.
package alu_pkg;

  localparam int unsigned RES_W   = 33;
  localparam int unsigned ERR_W   = 2;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned ENTRY_W = RES_W + ERR_W + OPC_W;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_DZ  = 1;

  localparam logic [OPC_W-1:0] OP_ADD = 4'b0100;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0101;
  localparam logic [OPC_W-1:0] OP_MUL = 4'b0110;
  localparam logic [OPC_W-1:0] OP_DIV = 4'b0111;
  localparam logic [OPC_W-1:0] OP_MOD = 4'b1000;

  typedef struct packed {
    logic [RES_W-1:0] c;
    logic [ERR_W-1:0] error;
    logic [OPC_W-1:0] opcode;
  } alu_entry_t;

  function automatic logic op_is_valid(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
           (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Result FIFO: storage, wrap-around pointers and occupancy; head falls back to the last popped
// entry while empty so the consumer side holds its final values.
module result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 39
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_last;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = o_empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: opcode filter, result FIFO, saturating error counters and sticky error status.
// Optional feature macro: ALU_RESULT_STICKY_EN enables the sticky_err register.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_c,
  input  logic [ERR_W-1:0] in_error,
  input  logic [OPC_W-1:0] in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_c,
  output logic [ERR_W-1:0] out_error,
  output logic [OPC_W-1:0] out_opcode,
  output logic [CNT_W-1:0] ovf_count,
  output logic [CNT_W-1:0] dz_count,
  input  logic             clr_counts,
  output logic             drop_pulse,
  output logic [ERR_W-1:0] sticky_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  alu_entry_t       w_in;
  alu_entry_t       w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_store;
  logic [CNT_W-1:0] r_ovf;
  logic [CNT_W-1:0] r_dz;
  logic             r_drop;

  assign w_in     = '{c: in_c, error: in_error, opcode: in_opcode};
  assign in_ready = ~w_full;
  assign w_accept = in_valid & ~w_full;
  assign w_store  = w_accept & op_is_valid(in_opcode);

  result_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_store),
    .i_data  (w_in),
    .i_pop   (out_ready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign out_valid  = ~w_empty;
  assign out_c      = w_head.c;
  assign out_error  = w_head.error;
  assign out_opcode = w_head.opcode;
  assign ovf_count  = r_ovf;
  assign dz_count   = r_dz;
  assign drop_pulse = r_drop;

  // Clear has priority over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf  <= '0;
      r_dz   <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_accept & ~op_is_valid(in_opcode);
      if (clr_counts) begin
        r_ovf <= '0;
        r_dz  <= '0;
      end else if (w_store) begin
        if (in_error[ERR_OVF] && (r_ovf != CNT_MAX)) r_ovf <= r_ovf + CNT_W'(1);
        if (in_error[ERR_DZ]  && (r_dz  != CNT_MAX)) r_dz  <= r_dz + CNT_W'(1);
      end
    end
  end

`ifdef ALU_RESULT_STICKY_EN
  logic [ERR_W-1:0] r_sticky;
  logic             w_pop;

  assign w_pop      = out_ready & ~w_empty;
  assign sticky_err = r_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_sticky <= '0;
    else if (clr_counts) r_sticky <= '0;
    else if (w_pop)      r_sticky <= r_sticky | w_head.error;
  end
`else
  assign sticky_err = '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (default instance plus a CNT_W=2 instance).
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] in_c;
  logic [1:0]  in_error;
  logic [3:0]  in_opcode;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_c;
  logic [1:0]  out_error;
  logic [3:0]  out_opcode;
  logic [7:0]  ovf_count;
  logic [7:0]  dz_count;
  logic        clr_counts;
  logic        drop_pulse;
  logic [1:0]  sticky_err;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [32:0] s_out_c;
  logic [1:0]  s_out_error;
  logic [3:0]  s_out_opcode;
  logic [1:0]  s_ovf_count;
  logic [1:0]  s_dz_count;
  logic        s_drop_pulse;
  logic [1:0]  s_sticky_err;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_sticky;

  always #5 clk = ~clk;

  alu_result_stage #(.DEPTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_c(in_c),
    .in_error(in_error), .in_opcode(in_opcode), .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_error(out_error), .out_opcode(out_opcode), .ovf_count(ovf_count),
    .dz_count(dz_count), .clr_counts(clr_counts), .drop_pulse(drop_pulse), .sticky_err(sticky_err)
  );

  alu_result_stage #(.DEPTH(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_c(in_c),
    .in_error(in_error), .in_opcode(in_opcode), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_c(s_out_c), .out_error(s_out_error), .out_opcode(s_out_opcode), .ovf_count(s_ovf_count),
    .dz_count(s_dz_count), .clr_counts(clr_counts), .drop_pulse(s_drop_pulse), .sticky_err(s_sticky_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [32:0] c, input logic [1:0] e, input logic [3:0] op);
    in_valid  = v;
    in_c      = c;
    in_error  = e;
    in_opcode = op;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; clr_counts = 1'b0;
    drive(1'b0, 33'd0, 2'b00, 4'b0000);
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_c", 64'(out_c), 64'd0);
    chk("rst_out_opcode", 64'(out_opcode), 64'd0);
    chk("rst_ovf", 64'(ovf_count), 64'd0);
    chk("rst_dz", 64'(dz_count), 64'd0);
    chk("rst_drop", 64'(drop_pulse), 64'd0);
    chk("rst_sticky", 64'(sticky_err), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Single push: visible the cycle after
    drive(1'b1, 33'd22, 2'b00, 4'b0100);
    #1 chk("lat_before", 64'(out_valid), 64'd0);
    tick();
    drive(1'b0, 33'd0, 2'b00, 4'b0000);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_c", 64'(out_c), 64'd22);
    chk("lat_op", 64'(out_opcode), 64'h4);
    chk("lat_ovf", 64'(ovf_count), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop_empty", 64'(out_valid), 64'd0);
    chk("pop_hold_c", 64'(out_c), 64'd22);

    // Fill past DEPTH with consumer stalled
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 33'(i), 2'b00, 4'b0100);
      #1 chk($sformatf("fill_ready_%0d", i), 64'(in_ready), (i <= 4) ? 64'd1 : 64'd0);
      if (i == 5) out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    drive(1'b0, 33'd0, 2'b00, 4'b0000);
    chk("full_after_pop", 64'(in_ready), 64'd1);
    chk("full_head", 64'(out_c), 64'd2);
    tick();
    chk("stall_hold", 64'(out_c), 64'd2);
    out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      chk($sformatf("drain_%0d", i), 64'(out_c), 64'(i));
      tick();
    end
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Error counters with continuous draining
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 33'(100 + i), 2'b01, 4'b0101);
      tick();
    end
    drive(1'b1, 33'd200, 2'b10, 4'b0111);
    tick();
    drive(1'b0, 33'd0, 2'b00, 4'b0000);
    chk("cnt_ovf", 64'(ovf_count), 64'd3);
    chk("cnt_dz", 64'(dz_count), 64'd1);
    chk("cnt_sat_ovf", 64'(s_ovf_count), 64'd3);
    tick();
`ifdef ALU_RESULT_STICKY_EN
    exp_sticky = 2'b11;
`else
    exp_sticky = 2'b00;
`endif
    chk("sticky_or", 64'(sticky_err), 64'(exp_sticky));
    clr_counts = 1'b1;
    drive(1'b1, 33'd55, 2'b01, 4'b0100);
    tick();
    clr_counts = 1'b0;
    drive(1'b0, 33'd0, 2'b00, 4'b0000);
    chk("clr_ovf", 64'(ovf_count), 64'd0);
    chk("clr_dz", 64'(dz_count), 64'd0);
    chk("clr_sticky", 64'(sticky_err), 64'd0);
    chk("clr_fifo_kept", 64'(out_c), 64'd55);
    tick();

    // Bad opcode is dropped
    drive(1'b1, 33'd7, 2'b01, 4'b0011);
    tick();
    drive(1'b0, 33'd0, 2'b00, 4'b0000);
    chk("drop_pulse", 64'(drop_pulse), 64'd1);
    chk("drop_empty", 64'(out_valid), 64'd0);
    chk("drop_ovf", 64'(ovf_count), 64'd0);
    tick();
    chk("drop_one_cycle", 64'(drop_pulse), 64'd0);

    // Saturation on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 33'(i), 2'b01, 4'b0100);
      tick();
    end
    drive(1'b0, 33'd0, 2'b00, 4'b0000);
    chk("sat_wide", 64'(ovf_count), 64'd5);
    chk("sat_narrow", 64'(s_ovf_count), 64'd3);
    tick();

    // Reset mid-stream
    out_ready = 1'b0; clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    drive(1'b1, 33'd9, 2'b10, 4'b0111);
    tick();
    drive(1'b1, 33'd10, 2'b00, 4'b0100);
    tick();
    drive(1'b0, 33'd0, 2'b00, 4'b0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`ifdef ALU_RESULT_STICKY_EN
    exp_sticky = 2'b10;
`else
    exp_sticky = 2'b00;
`endif
    chk("sticky_dz", 64'(sticky_err), 64'(exp_sticky));
    drive(1'b1, 33'd11, 2'b00, 4'b0110);
    tick();
    drive(1'b0, 33'd0, 2'b00, 4'b0000);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_sticky", 64'(sticky_err), 64'd0);
    chk("rst_async_c", 64'(out_c), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_empty", 64'(out_valid), 64'd0);
    drive(1'b1, 33'h1_0000_0001, 2'b00, 4'b1000);
    tick();
    drive(1'b0, 33'd0, 2'b00, 4'b0000);
    chk("post_rst_c", 64'(out_c), 64'h1_0000_0001);
    chk("post_rst_op", 64'(out_opcode), 64'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter DEPTH, default 4, result FIFO entries; power of two, 2..16.
REQ-002 Parameter CNT_W, default 8, width of each error counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  ALU result present this cycle.
REQ-006 in_ready  output  1  stage can accept a result.
REQ-007 in_c  input  33  ALU result C.
REQ-008 in_error  input  2  ALU error; bit0 add/sub overflow, bit1 divide-by-zero.
REQ-009 in_opcode  input  4  opcode that produced in_c.
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_ready  input  1  consumer takes head entry.
REQ-012 out_c, out_error, out_opcode  output  33/2/4  head entry fields.
REQ-013 ovf_count, dz_count  output  CNT_W each  saturating counts of error bit0 / bit1.
REQ-014 clr_counts  input  1  synchronous clear of counters and sticky status.
REQ-015 drop_pulse  output  1  one-cycle pulse: accepted result discarded for bad opcode.
REQ-016 sticky_err  output  2  OR of all popped out_error since last clear.

Function
REQ-017 Push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-018 in_ready = FIFO not full, from registered occupancy only; no combinational path from out_ready.
REQ-019 Valid opcodes 0100 (ADD), 0101 (SUB), 0110 (MUL), 0111 (DIV), 1000 (MOD); pushes with any other opcode are not stored, drop_pulse=1 the following cycle, counters unchanged.
REQ-020 Stored push: entry written at tail; out_valid=1 no earlier than the cycle after the push (1-cycle latency into an empty FIFO).
REQ-021 Head fields driven directly from storage; out_* stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous push and pop when not full and not empty: occupancy unchanged, order preserved.
REQ-023 Full: in_ready=0 even if pop occurs the same cycle; in_valid ignored.
REQ-024 Empty: out_valid=0; out_ready ignored; out_* hold last popped values.
REQ-025 Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
REQ-026 On stored push with in_error[0]=1, ovf_count+1; in_error[1]=1, dz_count+1; both bits increment both; saturate at 2^CNT_W-1.
REQ-027 clr_counts=1 sets both counters and sticky_err to 0 next cycle; clear wins over same-cycle increment or sticky update.
REQ-028 FIFO contents unaffected by clr_counts.

Reset
REQ-029 rst=1 asynchronously: FIFO empty, pointers 0, out_valid=0, in_ready=1 after release, out_c/out_error/out_opcode=0, counters 0, sticky_err=0, drop_pulse=0.
REQ-030 Reset mid-operation discards all stored entries; no partial pop or push completes.

Configuration
REQ-031 Macro ALU_RESULT_STICKY_EN: defined, sticky_err ORs out_error on each pop per REQ-016/027; undefined, sticky_err tied 2'b00 and its register is absent.

Structure
REQ-032 Shared package alu_pkg holds opcode constants (OP_ADD..OP_MOD), result width 33, error bit indices ERR_OVF=0, ERR_DZ=1, and a packed result-entry typedef {c, error, opcode}.
REQ-033 One sub-module result_fifo (parameterised DEPTH, entry width 39) holds storage, pointers, occupancy; top holds opcode filter, counters, sticky logic.

Verification
REQ-034 Reset, push {C=22, err=00, op=0100} -> out_valid next cycle, out_c=22, out_opcode=0100, counters 0.
REQ-035 DEPTH=4, out_ready=0, push 5 results 1..5 -> in_ready=0 after 4th, 5th not accepted; then pop all -> order 1,2,3,4.
REQ-036 Push op=0101 err=01 three times and op=0111 err=10 once -> ovf_count=3, dz_count=1; assert clr_counts with an err=01 push same cycle -> ovf_count=0.
REQ-037 Push op=0011 C=7 -> drop_pulse one cycle, FIFO stays empty, counters 0.
REQ-038 CNT_W=2, five err=01 pushes -> ovf_count saturates at 3.
REQ-039 Two entries queued, assert rst mid-stream -> out_valid=0 immediately, in_ready=1 after release; with ALU_RESULT_STICKY_EN, pop err=10 entry -> sticky_err=10, cleared by reset.
